// File: rtl/spu_issue_ctrl_pkg.sv
// Shared types and helpers for the SPU dual-issue controller.
// Optional feature macro used by the top: SPU_ISSUE_PERF_EN (performance counters).
package spu_issue_ctrl_pkg;

    localparam int NUM_REGS = 128;
    localparam int LAT_WD   = 3;
    localparam int REG_WD   = 7;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_FA   = 4'd1,
        OP_FM   = 4'd2,
        OP_A    = 4'd3,
        OP_SHL  = 4'd4,
        OP_LQD  = 4'd5,
        OP_STQD = 4'd6,
        OP_BR   = 4'd7
    } opcode_e;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_e;

    typedef struct packed {
        logic              vld;
        opcode_e           opcode;
        pipe_e             pipe;
        logic [REG_WD-1:0] rt;
        logic [REG_WD-1:0] ra;
        logic [REG_WD-1:0] rb;
        logic [REG_WD-1:0] rc;
        logic              ra_use;
        logic              rb_use;
        logic              rc_use;
        logic              rt_wr;
        logic [LAT_WD-1:0] lat;
    } issue_slot_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PAIR  = 2'd1,
        S_ONE   = 2'd2
    } issue_state_e;

    localparam issue_slot_t SLOT_ZERO = issue_slot_t'({$bits(issue_slot_t){1'b0}});

    // Scoreboard value loaded at issue: the consumer may issue lat cycles later, lat=0 behaves as 1.
    function automatic logic [LAT_WD-1:0] lat_to_cnt(input logic [LAT_WD-1:0] lat);
        return (lat == {LAT_WD{1'b0}}) ? {LAT_WD{1'b0}} : (lat - {{(LAT_WD-1){1'b0}}, 1'b1});
    endfunction

    // All used sources have a zero scoreboard count (rdy bit order: ra, rb, rc).
    function automatic logic slot_ready(input issue_slot_t s, input logic [2:0] rdy);
        return (~s.ra_use | rdy[0]) & (~s.rb_use | rdy[1]) & (~s.rc_use | rdy[2]);
    endfunction

    // Younger instruction c reads the register the older instruction p writes.
    function automatic logic raw_hazard(input issue_slot_t p, input issue_slot_t c);
        return p.rt_wr & ((c.ra_use & (c.ra == p.rt)) |
                          (c.rb_use & (c.rb == p.rt)) |
                          (c.rc_use & (c.rc == p.rt)));
    endfunction

    // Both instructions write the same target register.
    function automatic logic waw_hazard(input issue_slot_t p, input issue_slot_t c);
        return p.rt_wr & c.rt_wr & (p.rt == c.rt);
    endfunction

endpackage

// File: rtl/spu_issue_ctrl_scoreboard.sv
// Per-register latency scoreboard: a down-counter per architectural register,
// six source-ready lookups and two load ports (one per issue slot).
module spu_scoreboard
    import spu_issue_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0][REG_WD-1:0] src_idx,
    output logic [5:0]             src_rdy,
    input  logic [1:0]             ld_en,
    input  logic [1:0][REG_WD-1:0] ld_idx,
    input  logic [1:0][LAT_WD-1:0] ld_cnt
);

    logic [LAT_WD-1:0] cnt_r [NUM_REGS];

    // A source is ready once its producer's countdown has reached zero.
    always_comb begin
        src_rdy = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            src_rdy[k] = (cnt_r[src_idx[k]] == {LAT_WD{1'b0}});
        end
    end

    // Load on issue takes priority over the per-cycle decrement of the same entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                cnt_r[i] <= {LAT_WD{1'b0}};
            end else if (ld_en[0] && (ld_idx[0] == REG_WD'(i))) begin
                cnt_r[i] <= ld_cnt[0];
            end else if (ld_en[1] && (ld_idx[1] == REG_WD'(i))) begin
                cnt_r[i] <= ld_cnt[1];
            end else if (cnt_r[i] != {LAT_WD{1'b0}}) begin
                cnt_r[i] <= cnt_r[i] - {{(LAT_WD-1){1'b0}}, 1'b1};
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

endmodule

// File: rtl/spu_issue_ctrl.sv
// In-order dual-issue scheduler feeding the SPU even/odd pipes.
// Optional macro SPU_ISSUE_PERF_EN enables the stall/dual-issue counters;
// without it stall_cnt and dual_cnt are constant zero.
module spu_issue_ctrl
    import spu_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  issue_slot_t in_s0,
    input  issue_slot_t in_s1,
    input  logic        flush,
    output logic        ep_valid,
    output issue_slot_t ep_slot,
    output logic        op_valid,
    output issue_slot_t op_slot,
    output logic [31:0] stall_cnt,
    output logic [31:0] dual_cnt
);

    issue_state_e state_r, state_nxt_s;
    issue_slot_t  s0_r, s1_r;
    issue_slot_t  ep_slot_r, op_slot_r, ep_slot_s, op_slot_s;
    logic         ep_valid_r, op_valid_r, ep_iss_s, op_iss_s;
    logic         s0_rdy_s, s1_rdy_s, dual_ok_s;
    logic         iss0_s, iss1_s, all_done_s, accept_s;

    logic [5:0][REG_WD-1:0] src_idx_s;
    logic [5:0]             src_rdy_s;
    logic [1:0]             ld_en_s;
    logic [1:0][REG_WD-1:0] ld_idx_s;
    logic [1:0][LAT_WD-1:0] ld_cnt_s;

    // Scoreboard lookups for both buffered instructions; loads for whatever issues.
    assign src_idx_s = {s1_r.rc, s1_r.rb, s1_r.ra, s0_r.rc, s0_r.rb, s0_r.ra};
    assign ld_en_s   = {iss1_s & s1_r.rt_wr, iss0_s & s0_r.rt_wr};
    assign ld_idx_s  = {s1_r.rt, s0_r.rt};
    assign ld_cnt_s  = {lat_to_cnt(s1_r.lat), lat_to_cnt(s0_r.lat)};

    spu_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .src_idx (src_idx_s),
        .src_rdy (src_rdy_s),
        .ld_en   (ld_en_s),
        .ld_idx  (ld_idx_s),
        .ld_cnt  (ld_cnt_s)
    );

    assign s0_rdy_s  = slot_ready(s0_r, src_rdy_s[2:0]);
    assign s1_rdy_s  = slot_ready(s1_r, src_rdy_s[5:3]);
    assign dual_ok_s = s0_rdy_s & s1_rdy_s & (s0_r.pipe != s1_r.pipe) &
                       ~raw_hazard(s0_r, s1_r) & ~waw_hazard(s0_r, s1_r);

    // Issue decision from the buffer; flush suppresses all issue that cycle.
    always_comb begin
        iss0_s     = 1'b0;
        iss1_s     = 1'b0;
        all_done_s = 1'b0;
        case (state_r)
            S_EMPTY: begin
                all_done_s = 1'b1;
            end
            S_PAIR: begin
                iss0_s     = ~flush & s0_rdy_s;
                iss1_s     = ~flush & s0_rdy_s & dual_ok_s;
                all_done_s = s0_rdy_s & dual_ok_s;
            end
            S_ONE: begin
                iss1_s     = ~flush & s1_rdy_s;
                all_done_s = s1_rdy_s;
            end
            default: begin
                all_done_s = 1'b1;
            end
        endcase
    end

    assign in_ready = ~flush & all_done_s;
    assign accept_s = in_valid & in_ready;

    // Next-state: flush empties the buffer, an accept refills it, otherwise track issue progress.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = S_EMPTY;
        end else if (accept_s) begin
            state_nxt_s = in_s1.vld ? S_PAIR : S_ONE;
        end else begin
            case (state_r)
                S_EMPTY: state_nxt_s = S_EMPTY;
                S_PAIR: begin
                    if (iss1_s) begin
                        state_nxt_s = S_EMPTY;
                    end else if (iss0_s) begin
                        state_nxt_s = S_ONE;
                    end else begin
                        state_nxt_s = S_PAIR;
                    end
                end
                S_ONE: begin
                    if (iss1_s) begin
                        state_nxt_s = S_EMPTY;
                    end else begin
                        state_nxt_s = S_ONE;
                    end
                end
                default: state_nxt_s = S_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction buffer; a lone instruction lives in the s1 slot so S_ONE always issues s1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_r <= SLOT_ZERO;
            s1_r <= SLOT_ZERO;
        end else if (accept_s && in_s1.vld) begin
            s0_r <= in_s0;
            s1_r <= in_s1;
        end else if (accept_s) begin
            s0_r <= s0_r;
            s1_r <= in_s0;
        end else begin
            s0_r <= s0_r;
            s1_r <= s1_r;
        end
    end

    // Steer each issuing instruction to the pipe named in its pipe field.
    always_comb begin
        ep_iss_s  = 1'b0;
        ep_slot_s = s0_r;
        op_iss_s  = 1'b0;
        op_slot_s = s1_r;
        if (iss0_s && (s0_r.pipe == PIPE_EVEN)) begin
            ep_iss_s  = 1'b1;
            ep_slot_s = s0_r;
        end else if (iss1_s && (s1_r.pipe == PIPE_EVEN)) begin
            ep_iss_s  = 1'b1;
            ep_slot_s = s1_r;
        end else begin
            ep_iss_s  = 1'b0;
        end
        if (iss0_s && (s0_r.pipe == PIPE_ODD)) begin
            op_iss_s  = 1'b1;
            op_slot_s = s0_r;
        end else if (iss1_s && (s1_r.pipe == PIPE_ODD)) begin
            op_iss_s  = 1'b1;
            op_slot_s = s1_r;
        end else begin
            op_iss_s  = 1'b0;
        end
    end

    // Registered issue ports; slots hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ep_valid_r <= 1'b0;
            op_valid_r <= 1'b0;
            ep_slot_r  <= SLOT_ZERO;
            op_slot_r  <= SLOT_ZERO;
        end else begin
            ep_valid_r <= ep_iss_s;
            op_valid_r <= op_iss_s;
            ep_slot_r  <= ep_iss_s ? ep_slot_s : ep_slot_r;
            op_slot_r  <= op_iss_s ? op_slot_s : op_slot_r;
        end
    end

    assign ep_valid = ep_valid_r;
    assign op_valid = op_valid_r;
    assign ep_slot  = ep_slot_r;
    assign op_slot  = op_slot_r;

`ifdef SPU_ISSUE_PERF_EN
    logic [31:0] stall_cnt_r, dual_cnt_r;
    logic        stall_s;

    assign stall_s = (state_r != S_EMPTY) & ~flush & ~iss0_s & ~iss1_s;

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            dual_cnt_r  <= 32'd0;
        end else begin
            stall_cnt_r <= stall_s ? (stall_cnt_r + 32'd1) : stall_cnt_r;
            dual_cnt_r  <= (iss0_s & iss1_s) ? (dual_cnt_r + 32'd1) : dual_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign dual_cnt  = dual_cnt_r;
`else
    assign stall_cnt = 32'd0;
    assign dual_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Self-checking bench for spu_issue_ctrl: directed scenarios plus randomized traffic,
// all checked against a timestamp-based reference model of the issue rules.
`timescale 1ns/1ps
module tb_spu_issue_ctrl;
    import spu_issue_ctrl_pkg::*;

`ifdef SPU_ISSUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, ep_valid, op_valid;
    issue_slot_t in_s0, in_s1, ep_slot, op_slot;
    logic [31:0] stall_cnt, dual_cnt;

    always #5 clk = ~clk;

    spu_issue_ctrl dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .in_s0 (in_s0), .in_s1 (in_s1), .flush (flush),
        .ep_valid (ep_valid), .ep_slot (ep_slot),
        .op_valid (op_valid), .op_slot (op_slot),
        .stall_cnt (stall_cnt), .dual_cnt (dual_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending queue in program order, and for each register the
    // first cycle at which a consumer may issue.
    issue_slot_t     q[$];
    longint unsigned rdy_at [NUM_REGS];
    longint unsigned cyc = 0;
    logic            m_ep_v, m_op_v;
    issue_slot_t     m_ep_s, m_op_s;
    logic [31:0]     m_stall, m_dual;

    function automatic bit m_ready(issue_slot_t s);
        bit r = 1'b1;
        if (s.ra_use && (cyc < rdy_at[s.ra])) r = 1'b0;
        if (s.rb_use && (cyc < rdy_at[s.rb])) r = 1'b0;
        if (s.rc_use && (cyc < rdy_at[s.rc])) r = 1'b0;
        return r;
    endfunction

    function automatic bit m_reads(issue_slot_t c, logic [6:0] r);
        return (c.ra_use && c.ra == r) || (c.rb_use && c.rb == r) || (c.rc_use && c.rc == r);
    endfunction

    function automatic issue_slot_t mk(bit odd, int rt, bit wr, int ra, bit ra_u, int lat);
        issue_slot_t s;
        s = SLOT_ZERO;
        s.vld = 1'b1; s.opcode = OP_A;
        s.pipe = odd ? PIPE_ODD : PIPE_EVEN;
        s.rt = 7'(rt); s.rt_wr = wr; s.ra = 7'(ra); s.ra_use = ra_u;
        s.rb = 7'(ra + 1); s.rc = 7'(ra + 2); s.lat = 3'(lat);
        return s;
    endfunction

    function automatic issue_slot_t rand_slot();
        issue_slot_t s;
        s.vld    = 1'b1;
        s.opcode = opcode_e'(4'($urandom_range(0, 7)));
        s.pipe   = $urandom_range(0, 1) ? PIPE_ODD : PIPE_EVEN;
        s.rt     = 7'($urandom_range(0, 7));
        s.ra     = 7'($urandom_range(0, 7));
        s.rb     = 7'($urandom_range(0, 7));
        s.rc     = 7'($urandom_range(0, 7));
        s.ra_use = 1'($urandom_range(0, 1));
        s.rb_use = 1'($urandom_range(0, 1));
        s.rc_use = ($urandom_range(0, 3) == 0);
        s.rt_wr  = ($urandom_range(0, 4) != 0);
        s.lat    = 3'($urandom_range(0, 7));
        return s;
    endfunction

    // One clock: drive inputs, check registered outputs from the previous decision,
    // check in_ready, then advance the model across the edge.
    task automatic run_cycle(input bit v, input issue_slot_t a, input issue_slot_t b, input bit f);
        issue_slot_t iss[$];
        bit          exp_rdy;
        in_valid = v; in_s0 = a; in_s1 = b; flush = f;
        @(negedge clk);
        n_cmp++;
        if (ep_valid !== m_ep_v) begin
            n_err++; $display("FAIL ep_valid cyc=%0d got=%b exp=%b", cyc, ep_valid, m_ep_v);
        end
        n_cmp++;
        if (op_valid !== m_op_v) begin
            n_err++; $display("FAIL op_valid cyc=%0d got=%b exp=%b", cyc, op_valid, m_op_v);
        end
        n_cmp++;
        if (ep_slot !== m_ep_s) begin
            n_err++; $display("FAIL ep_slot cyc=%0d got=%h exp=%h", cyc, ep_slot, m_ep_s);
        end
        n_cmp++;
        if (op_slot !== m_op_s) begin
            n_err++; $display("FAIL op_slot cyc=%0d got=%h exp=%h", cyc, op_slot, m_op_s);
        end
        n_cmp++;
        if (stall_cnt !== (PERF ? m_stall : 32'd0)) begin
            n_err++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, PERF ? m_stall : 32'd0);
        end
        n_cmp++;
        if (dual_cnt !== (PERF ? m_dual : 32'd0)) begin
            n_err++; $display("FAIL dual_cnt cyc=%0d got=%0d exp=%0d", cyc, dual_cnt, PERF ? m_dual : 32'd0);
        end
        // Oldest ready instruction issues; the younger one joins it only when independent.
        if (!f && q.size() > 0 && m_ready(q[0])) begin
            iss.push_back(q[0]);
            if (q.size() == 2 && m_ready(q[1]) && q[1].pipe != q[0].pipe &&
                !(q[0].rt_wr && m_reads(q[1], q[0].rt)) &&
                !(q[0].rt_wr && q[1].rt_wr && q[0].rt == q[1].rt))
                iss.push_back(q[1]);
        end
        exp_rdy = !f && (iss.size() == q.size());
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            n_err++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
        end
        if (!f && q.size() > 0 && iss.size() == 0) m_stall++;
        if (iss.size() == 2) m_dual++;
        m_ep_v = 1'b0; m_op_v = 1'b0;
        foreach (iss[k]) begin
            if (iss[k].pipe == PIPE_EVEN) begin m_ep_v = 1'b1; m_ep_s = iss[k]; end
            else begin m_op_v = 1'b1; m_op_s = iss[k]; end
            if (iss[k].rt_wr) rdy_at[iss[k].rt] = cyc + ((iss[k].lat == 3'd0) ? 1 : iss[k].lat);
        end
        repeat (iss.size()) void'(q.pop_front());
        if (f) q.delete();
        else if (v && exp_rdy) begin
            q.push_back(a);
            if (b.vld) q.push_back(b);
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, rand_slot(), rand_slot(), 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; in_valid = 1'($urandom_range(0, 1)); flush = 1'b0;
        in_s0 = rand_slot(); in_s1 = rand_slot();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        foreach (rdy_at[i]) rdy_at[i] = 0;
        m_ep_v = 1'b0; m_op_v = 1'b0; m_ep_s = SLOT_ZERO; m_op_s = SLOT_ZERO;
        m_stall = 32'd0; m_dual = 32'd0;
        cyc += longint'(n);
    endtask

    task automatic test_reset();
        do_reset(3);
        @(negedge clk);
        n_cmp++;
        if (ep_valid !== 1'b0 || op_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got=%b%b exp=00", ep_valid, op_valid);
        end
        n_cmp++;
        if (ep_slot !== SLOT_ZERO || op_slot !== SLOT_ZERO) begin
            n_err++; $display("FAIL reset_slots got=%h/%h exp=0", ep_slot, op_slot);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_cmp++;
        if (stall_cnt !== 32'd0 || dual_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, dual_cnt);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_dual_independent();
        do_reset(2);
        run_cycle(1'b1, mk(0, 5, 1, 1, 1, 2), mk(1, 6, 1, 2, 1, 3), 1'b0);
        run_cycle(1'b0, rand_slot(), rand_slot(), 1'b0);
        n_cmp++;
        if (!(ep_valid === 1'b1 && op_valid === 1'b1)) begin
            n_err++; $display("FAIL dual_same_cycle got=%b%b exp=11", ep_valid, op_valid);
        end
        idle(2);
        n_cmp++;
        if (dual_cnt !== (PERF ? 32'd1 : 32'd0)) begin
            n_err++; $display("FAIL dual_cnt_one got=%0d exp=%0d", dual_cnt, PERF ? 1 : 0);
        end
    endtask

    task automatic test_raw_latency();
        do_reset(2);
        run_cycle(1'b1, mk(0, 10, 1, 1, 0, 6), mk(1, 11, 1, 10, 1, 1), 1'b0);
        idle(9);
        n_cmp++;
        if (stall_cnt !== (PERF ? 32'd5 : 32'd0)) begin
            n_err++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? 5 : 0);
        end
    endtask

    task automatic test_same_pipe();
        do_reset(2);
        run_cycle(1'b1, mk(0, 1, 1, 4, 1, 1), mk(0, 2, 1, 5, 1, 1), 1'b0);
        run_cycle(1'b0, rand_slot(), rand_slot(), 1'b0);
        run_cycle(1'b1, mk(1, 3, 0, 6, 0, 2), SLOT_ZERO, 1'b0);
        idle(3);
    endtask

    task automatic test_waw();
        do_reset(2);
        run_cycle(1'b1, mk(0, 3, 1, 1, 0, 2), mk(1, 3, 1, 2, 0, 5), 1'b0);
        run_cycle(1'b0, rand_slot(), rand_slot(), 1'b0);
        run_cycle(1'b1, mk(0, 7, 1, 3, 1, 1), SLOT_ZERO, 1'b0);
        idle(8);
    endtask

    task automatic test_flush();
        do_reset(2);
        run_cycle(1'b1, mk(0, 20, 1, 1, 0, 7), SLOT_ZERO, 1'b0);
        run_cycle(1'b1, mk(1, 21, 1, 20, 1, 1), SLOT_ZERO, 1'b0);
        run_cycle(1'b0, rand_slot(), rand_slot(), 1'b0);
        run_cycle(1'b1, mk(0, 22, 1, 1, 0, 1), mk(1, 23, 1, 2, 0, 1), 1'b1);
        run_cycle(1'b1, mk(0, 24, 1, 1, 0, 1), mk(1, 25, 1, 2, 0, 1), 1'b0);
        idle(8);
    endtask

    task automatic test_reset_mid_stall();
        do_reset(2);
        run_cycle(1'b1, mk(0, 10, 1, 1, 0, 6), SLOT_ZERO, 1'b0);
        run_cycle(1'b1, mk(1, 12, 1, 10, 1, 1), SLOT_ZERO, 1'b0);
        idle(2);
        do_reset(1);
        run_cycle(1'b1, mk(1, 13, 1, 10, 1, 1), SLOT_ZERO, 1'b0);
        idle(2);
    endtask

    task automatic test_random();
        do_reset(2);
        for (int i = 0; i < 2000; i++) begin
            issue_slot_t b;
            b = rand_slot();
            b.vld = ($urandom_range(0, 9) < 7);
            run_cycle(($urandom_range(0, 3) != 0), rand_slot(), b, ($urandom_range(0, 24) == 0));
        end
        idle(10);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_s0 = SLOT_ZERO; in_s1 = SLOT_ZERO;
        test_reset();
        test_dual_independent();
        test_raw_latency();
        test_same_pipe();
        test_waw();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
